req_ack_responder: RTL and testbench



---
 rtl/req_ack_responder.sv | 147 ++++++++++++++
 tb/tb_req_ack_responder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/req_ack_responder.sv
// req_ack_responder
//   Request/acknowledge responder. Each accepted request travels down a token
//   delay line and leaves as exactly one single-cycle ack, ACK_LATENCY cycles
//   after the accepting cycle. Every cycle of hold adds one cycle to that delay.
//   Requests are refused while in reset, while hold is high, or while
//   MAX_OUTSTANDING tokens are accepted but not yet acked. Refusals set a sticky
//   overflow flag and bump a saturating drop counter.
//
// Ports
//   clk          clock, all state on posedge
//   rst_n        synchronous active-low reset
//   req          request, accepted on an edge where req && ready
//   hold         freezes the delay line and refuses new requests
//   clr_err      clears overflow and drop_cnt (a refusal on the same edge wins)
//   ready        combinational: rst_n && !hold && outstanding < MAX_OUTSTANDING
//   ack          registered single-cycle acknowledge
//   outstanding  accepted requests not yet acked (ack cycle inclusive)
//   overflow     sticky flag, a request was refused
//   drop_cnt     saturating count of refused requests
//
// Build option
//   REQ_ACK_RESPONDER_SVA_EN  embeds concurrent/immediate assertions and covers.
//                             Without it the module has no assertion code and
//                             behaves identically.

module req_ack_responder #(
  parameter int unsigned ACK_LATENCY     = 3,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DROP_CNT_W      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   req,
  input  logic                                   hold,
  input  logic                                   clr_err,
  output logic                                   ready,
  output logic                                   ack,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   overflow,
  output logic [DROP_CNT_W-1:0]                  drop_cnt
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_O = OUT_W'(MAX_OUTSTANDING);

  logic [ACK_LATENCY-1:0] pipe;
  logic [ACK_LATENCY-1:0] pipe_next;
  logic                   accept;
  logic                   refuse;

  assign ready  = rst_n && !hold && (outstanding < MAX_O);
  assign accept = req && ready;
  assign refuse = req && !ready;
  assign ack    = pipe[ACK_LATENCY-1];

  // Hold freezes every stage except the last, which is cleared so a token
  // sitting at the output acks exactly once. Written so ACK_LATENCY=1 needs
  // no special case: the single stage is both entry and exit.
  always_comb begin
    pipe_next = pipe;
    if (!hold) begin
      pipe_next[0] = accept;
      for (int unsigned i = 1; i < ACK_LATENCY; i++) begin
        pipe_next[i] = pipe[i-1];
      end
    end
    if (hold) begin
      pipe_next[ACK_LATENCY-1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe        <= '0;
      outstanding <= '0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      pipe <= pipe_next;

      case ({accept, ack})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (refuse) begin
        overflow <= 1'b1;
        if (clr_err) begin
          drop_cnt <= DROP_CNT_W'(1);
        end else if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
      end else if (clr_err) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

`ifdef REQ_ACK_RESPONDER_SVA_EN
  default clocking sva_cb @(posedge clk); endclocking
  default disable iff (!rst_n);

  // A token is queued directly behind the one currently acking: ack may then
  // legitimately be high on the following cycle too.
  logic queued;

  if (ACK_LATENCY == 1) begin : g_lat1
    assign queued = accept && !hold;
    a_latency: assert property (accept |=> ack);
  end else begin : g_latn
    assign queued = pipe[ACK_LATENCY-2] && !hold;
    a_latency: assert property (accept ##1 (!hold)[*ACK_LATENCY-1] |=> ack);
  end

  a_single_ack: assert property (ack && !queued |=> !ack);
  a_out_bound:  assert property (outstanding <= MAX_O);
  a_refuse:     assert property (refuse |=> overflow);

  c_full:       cover property (outstanding == MAX_O);
  c_hold_ack:   cover property (hold ##1 ack);

  logic past_valid;
  logic prev_refuse;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      past_valid  <= 1'b0;
      prev_refuse <= 1'b0;
    end else begin
      past_valid  <= 1'b1;
      prev_refuse <= refuse;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && past_valid) begin
      ia_out_bound: assert (outstanding <= MAX_O);
      if (prev_refuse) begin
        ia_refuse: assert (overflow);
      end
    end
  end
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
module tb_req_ack_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic       hold;
  logic       clr_err;
  logic       ready;
  logic       ack;
  logic [1:0] outstanding;
  logic       overflow;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  req_ack_responder #(
    .ACK_LATENCY     (3),
    .MAX_OUTSTANDING (2),
    .DROP_CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .hold        (hold),
    .clr_err     (clr_err),
    .ready       (ready),
    .ack         (ack),
    .outstanding (outstanding),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc_n, got, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs for this cycle (-1 = don't care),
  // then advance past the next rising edge.
  task automatic cyc(input logic r, input logic q, input logic h, input logic c,
                     input int e_rdy, input int e_ack, input int e_out,
                     input int e_ovf, input int e_drop);
    rst_n = r; req = q; hold = h; clr_err = c;
    #1;
    if (e_rdy  >= 0) check("ready",       {31'b0, ready},       e_rdy);
    if (e_ack  >= 0) check("ack",         {31'b0, ack},         e_ack);
    if (e_out  >= 0) check("outstanding", {30'b0, outstanding}, e_out);
    if (e_ovf  >= 0) check("overflow",    {31'b0, overflow},    e_ovf);
    if (e_drop >= 0) check("drop_cnt",    {24'b0, drop_cnt},    e_drop);
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  initial begin
    // reset with req held high, then a single request at cycle 5
    cyc(0,1,0,0, 0,-1,-1,-1,-1);   // 0
    cyc(0,1,0,0, 0, 0, 0, 0, 0);   // 1
    cyc(1,0,0,0, 1, 0, 0, 0, 0);   // 2
    cyc(1,0,0,0, 1, 0, 0, 0, 0);   // 3
    cyc(1,0,0,0, 1, 0, 0, 0, 0);   // 4
    cyc(1,1,0,0, 1, 0, 0, 0, 0);   // 5 accept
    cyc(1,0,0,0, 1, 0, 1, 0, 0);   // 6
    cyc(1,0,0,0, 1, 0, 1, 0, 0);   // 7
    cyc(1,0,0,0, 1, 1, 1, 0, 0);   // 8 ack
    cyc(1,0,0,0, 1, 0, 0, 0, 0);   // 9
    cyc(1,0,0,0, 1, 0, 0, 0, 0);   // 10

    // back-to-back requests: third one refused at the outstanding limit
    cyc(1,1,0,0, 1, 0, 0, 0, 0);   // 11 accept
    cyc(1,1,0,0, 1, 0, 1, 0, 0);   // 12 accept
    cyc(1,1,0,0, 0, 0, 2, 0, 0);   // 13 refuse
    cyc(1,0,0,0, 0, 1, 2, 1, 1);   // 14 ack
    cyc(1,0,0,0, 1, 1, 1, 1, 1);   // 15 ack
    cyc(1,0,0,0, 1, 0, 0, 1, 1);   // 16
    cyc(1,0,0,1, 1, 0, 0, 1, 1);   // 17 clr_err
    cyc(1,0,0,0, 1, 0, 0, 0, 0);   // 18

    // hold for two cycles stretches latency; req during hold is refused
    cyc(1,1,0,0, 1, 0, 0, 0, 0);   // 19 accept
    cyc(1,0,1,0, 0, 0, 1, 0, 0);   // 20 hold
    cyc(1,1,1,0, 0, 0, 1, 0, 0);   // 21 hold + refuse
    cyc(1,0,0,0, 1, 0, 1, 1, 1);   // 22
    cyc(1,0,0,0, 1, 0, 1, 1, 1);   // 23
    cyc(1,0,0,0, 1, 1, 1, 1, 1);   // 24 ack
    cyc(1,0,0,0, 1, 0, 0, 1, 1);   // 25

    // hold rises while the token is at the output stage: acks once only
    cyc(1,1,0,0, 1, 0, 0, 1, 1);   // 26 accept
    cyc(1,0,0,0, 1, 0, 1, 1, 1);   // 27
    cyc(1,0,0,0, 1, 0, 1, 1, 1);   // 28
    cyc(1,0,1,0, 0, 1, 1, 1, 1);   // 29 ack, hold rises
    cyc(1,0,1,0, 0, 0, 0, 1, 1);   // 30
    cyc(1,0,0,0, 1, 0, 0, 1, 1);   // 31
    cyc(1,0,0,0, 1, 0, 0, 1, 1);   // 32

    // 300 refusals on top of drop_cnt=1 saturate at 255
    for (int i = 0; i < 300; i++) cyc(1,1,1,0, 0,-1,-1,-1,-1);
    cyc(1,0,0,0, 1, 0, 0, 1, 255);
    cyc(1,0,0,1, 1, 0, 0, 1, 255); // clr_err alone
    cyc(1,1,1,1, 0, 0, 0, 0, 0);   // clr_err with refuse on same edge
    cyc(1,0,0,0, 1, 0, 0, 1, 1);

    // reset with two tokens in flight discards them
    cyc(1,1,0,0, 1, 0, 0, 1, 1);   // accept
    cyc(1,1,0,0, 1, 0, 1, 1, 1);   // accept
    cyc(0,0,0,0, 0, 0, 2, 1, 1);   // reset low one cycle
    cyc(1,0,0,0, 1, 0, 0, 0, 0);
    cyc(1,0,0,0, 1, 0, 0, 0, 0);
    cyc(1,0,0,0, 1, 0, 0, 0, 0);
    cyc(1,0,0,0, 1, 0, 0, 0, 0);
    cyc(1,1,0,0, 1, 0, 0, 0, 0);   // accept
    cyc(1,0,0,0, 1, 0, 1, 0, 0);
    cyc(1,0,0,0, 1, 0, 1, 0, 0);
    cyc(1,0,0,0, 1, 1, 1, 0, 0);   // ack at nominal latency
    cyc(1,0,0,0, 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
